// File: rtl/branch_predictor_pkg.sv
// Shared widths and 2-bit direction counter encoding for the fetch-side predictor.
package branch_predictor_pkg;

  localparam int unsigned DATA_BUS_BITS = 64;
  localparam int unsigned BP_IDX_BITS   = 6;
  localparam int unsigned BP_TAG_BITS   = 12;
  localparam int unsigned BP_CNT_BITS   = 32;

  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'b00,
    BP_WEAK_NT   = 2'b01,
    BP_WEAK_T    = 2'b10,
    BP_STRONG_T  = 2'b11
  } bp_ctr_e;

  function automatic logic bp_ctr_taken(input bp_ctr_e c);
    return (c == BP_WEAK_T) || (c == BP_STRONG_T);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next value of a 2-bit saturating direction counter given the resolved outcome.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e ctr,
  input  logic    taken,
  output bp_ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      BP_STRONG_NT: ctr_next = taken ? BP_WEAK_NT  : BP_STRONG_NT;
      BP_WEAK_NT:   ctr_next = taken ? BP_WEAK_T   : BP_STRONG_NT;
      BP_WEAK_T:    ctr_next = taken ? BP_STRONG_T : BP_WEAK_NT;
      BP_STRONG_T:  ctr_next = taken ? BP_STRONG_T : BP_WEAK_T;
      default:      ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-latency fetch prediction,
// execute-stage training and mispredict redirect, plus branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN     = DATA_BUS_BITS,
  parameter int unsigned IDX_BITS = BP_IDX_BITS,
  parameter int unsigned TAG_BITS = BP_TAG_BITS,
  parameter int unsigned CNT_BITS = BP_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     f_pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  input  logic                ex_valid,
  input  logic                ex_branchOp,
  input  logic                ex_taken,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic [XLEN-1:0]     ex_target,
  input  logic                ex_pred_taken,
  input  logic [XLEN-1:0]     ex_pred_target,
  output logic                mispredict,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [CNT_BITS-1:0] stat_branches,
  output logic [CNT_BITS-1:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  bp_ctr_e             ctr_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_BITS-1:0] f_tag, ex_tag;
  logic                f_hit, ex_hit;
  bp_ctr_e             ex_ctr, ctr_next;
  logic                upd_hit, alloc, inval, tgt_we;

  assign f_idx  = f_pc[IDX_BITS+1:2];
  assign f_tag  = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Fetch reads pre-edge table contents; a same-cycle EX write is not bypassed.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && bp_ctr_taken(ctr_q[f_idx]);
  assign pred_target = pred_taken ? tgt_q[f_idx] : f_pc + XLEN'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctr = ctr_q[ex_idx];

  bp_sat_counter u_sat (
    .ctr      (ex_ctr),
    .taken    (ex_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_branchOp)
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
      else
        mispredict = ex_pred_taken;
    end
  end

  assign redirect_pc = (ex_branchOp && ex_taken) ? ex_target : ex_pc + XLEN'(4);

  assign upd_hit = ex_valid &&  ex_branchOp &&  ex_hit;
  assign alloc   = ex_valid &&  ex_branchOp && !ex_hit && ex_taken;
  assign inval   = ex_valid && !ex_branchOp &&  ex_hit;
  assign tgt_we  = alloc || (upd_hit && ex_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      ctr_q            <= '{default: BP_WEAK_NT};
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (alloc) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= BP_WEAK_T;
      end else if (upd_hit) begin
        ctr_q[ex_idx]   <= ctr_next;
      end else if (inval) begin
        valid_q[ex_idx] <= 1'b0;
      end
      if (ex_valid && ex_branchOp)
        stat_branches <= stat_branches + CNT_BITS'(1);
      if (mispredict)
        stat_mispredicts <= stat_mispredicts + CNT_BITS'(1);
    end
  end

  // Tag and target need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (tgt_we)
      tgt_q[ex_idx] <= ex_target;
    if (alloc)
      tag_q[ex_idx] <= ex_tag;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued at drive time, checked at negedge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid, ex_branchOp, ex_taken, ex_pred_taken;
  logic [63:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .f_pc             (f_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_branchOp      (ex_branchOp),
    .ex_taken         (ex_taken),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    string       nm;
    logic [63:0] fpc;
    logic        v, bop, tk;
    logic [63:0] pc, tgt;
    logic        ppt;
    logic [63:0] ppg;
    logic        e_pt;
    logic [63:0] e_ptg;
    logic        e_mp;
    logic [63:0] e_rpc;
  } step_t;

  typedef struct {
    string       nm;
    logic        pt;
    logic [63:0] ptg;
    logic        mp;
    logic        chk_rpc;
    logic [63:0] rpc;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          failed = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;

  function automatic step_t mk(input string nm, input logic [63:0] fpc,
                               input logic v, input logic bop, input logic tk,
                               input logic [63:0] pc, input logic [63:0] tgt,
                               input logic ppt, input logic [63:0] ppg,
                               input logic e_pt, input logic [63:0] e_ptg,
                               input logic e_mp, input logic [63:0] e_rpc);
    step_t s;
    s.nm = nm; s.fpc = fpc; s.v = v; s.bop = bop; s.tk = tk;
    s.pc = pc; s.tgt = tgt; s.ppt = ppt; s.ppg = ppg;
    s.e_pt = e_pt; s.e_ptg = e_ptg; s.e_mp = e_mp; s.e_rpc = e_rpc;
    return s;
  endfunction

  function automatic step_t idle(input string nm, input logic [63:0] fpc,
                                 input logic e_pt, input logic [63:0] e_ptg);
    return mk(nm, fpc, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0, e_pt, e_ptg, 0, 64'h0);
  endfunction

  task automatic drive_step(input step_t s);
    exp_t e;
    f_pc = s.fpc; ex_valid = s.v; ex_branchOp = s.bop; ex_taken = s.tk;
    ex_pc = s.pc; ex_target = s.tgt; ex_pred_taken = s.ppt; ex_pred_target = s.ppg;
    e.nm = s.nm; e.pt = s.e_pt; e.ptg = s.e_ptg; e.mp = s.e_mp;
    e.chk_rpc = s.v; e.rpc = s.e_rpc;
    sb.push_back(e);
    if (s.v && s.bop) exp_br++;
    if (s.e_mp) exp_mp++;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    exp_br = 0; exp_mp = 0;
    drive_step(idle("reset_fetch", 64'h1000, 0, 64'h1004));
    @(negedge clk);
    e = sb.pop_front();
    tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
    tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
    tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL reset stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL reset stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_allocate();
    step_t st[$];
    exp_t  e;
    st.push_back(mk("alloc_same_cycle", 64'h1000, 1, 1, 1, 64'h1000, 64'h2000, 0, 64'h1004, 0, 64'h1004, 1, 64'h2000));
    st.push_back(idle("alloc_predict", 64'h1000, 1, 64'h2000));
    foreach (st[i]) begin
      drive_step(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
      tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
      tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
      if (e.chk_rpc) begin tests_run++; if (redirect_pc !== e.rpc) begin failed++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end end
      @(posedge clk); #1;
    end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL alloc stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL alloc stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
  endtask

  task automatic test_saturation();
    step_t st[$];
    exp_t  e;
    for (int k = 0; k < 4; k++)
      st.push_back(mk($sformatf("sat_taken%0d", k), 64'h1000, 1, 1, 1, 64'h1000, 64'h2000, 1, 64'h2000, 1, 64'h2000, 0, 64'h2000));
    st.push_back(mk("sat_nt1", 64'h1000, 1, 1, 0, 64'h1000, 64'h1004, 1, 64'h2000, 1, 64'h2000, 1, 64'h1004));
    st.push_back(mk("sat_nt2", 64'h1000, 1, 1, 0, 64'h1000, 64'h1004, 1, 64'h2000, 1, 64'h2000, 1, 64'h1004));
    st.push_back(idle("sat_weak_nt", 64'h1000, 0, 64'h1004));
    foreach (st[i]) begin
      drive_step(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
      tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
      tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
      if (e.chk_rpc) begin tests_run++; if (redirect_pc !== e.rpc) begin failed++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end end
      @(posedge clk); #1;
    end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL sat stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL sat stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
  endtask

  task automatic test_alias_conflict();
    step_t st[$];
    exp_t  e;
    st.push_back(mk("alias_retrain", 64'h1000, 1, 1, 1, 64'h1000, 64'h2000, 0, 64'h1004, 0, 64'h1004, 1, 64'h2000));
    st.push_back(mk("alias_replace", 64'h1000, 1, 1, 1, 64'h1100, 64'h5000, 0, 64'h1104, 1, 64'h2000, 1, 64'h5000));
    st.push_back(idle("alias_old_gone", 64'h1000, 0, 64'h1004));
    st.push_back(idle("alias_new_hit", 64'h1100, 1, 64'h5000));
    foreach (st[i]) begin
      drive_step(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
      tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
      tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
      if (e.chk_rpc) begin tests_run++; if (redirect_pc !== e.rpc) begin failed++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end end
      @(posedge clk); #1;
    end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL alias stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL alias stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
  endtask

  task automatic test_nonbranch_alias();
    step_t st[$];
    exp_t  e;
    st.push_back(mk("nb_miss_clean", 64'h1100, 1, 0, 0, 64'h1204, 64'h1208, 0, 64'h1208, 1, 64'h5000, 0, 64'h1208));
    st.push_back(mk("nb_alias", 64'h1100, 1, 0, 0, 64'h1100, 64'h1104, 1, 64'h5000, 1, 64'h5000, 1, 64'h1104));
    st.push_back(idle("nb_invalidated", 64'h1100, 0, 64'h1104));
    foreach (st[i]) begin
      drive_step(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
      tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
      tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
      if (e.chk_rpc) begin tests_run++; if (redirect_pc !== e.rpc) begin failed++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end end
      @(posedge clk); #1;
    end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL nb stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL nb stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
  endtask

  task automatic test_target_wrap();
    step_t st[$];
    exp_t  e;
    st.push_back(mk("tgt_alloc", 64'h1204, 1, 1, 1, 64'h1204, 64'h3000, 0, 64'h1208, 0, 64'h1208, 1, 64'h3000));
    st.push_back(mk("tgt_mismatch", 64'h1204, 1, 1, 1, 64'h1204, 64'h4000, 1, 64'h3000, 1, 64'h3000, 1, 64'h4000));
    st.push_back(idle("tgt_updated", 64'h1204, 1, 64'h4000));
    st.push_back(mk("hit_nt", 64'h1204, 1, 1, 0, 64'h1204, 64'h1208, 1, 64'h4000, 1, 64'h4000, 1, 64'h1208));
    st.push_back(idle("tgt_kept", 64'h1204, 1, 64'h4000));
    st.push_back(mk("ex_invalid_masked", 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 64'h1204, 64'h9000, 0, 64'h0, 0, 64'h0, 0, 64'h0));
    st.push_back(idle("masked_no_train", 64'h1204, 1, 64'h4000));
    foreach (st[i]) begin
      drive_step(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
      tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
      tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
      if (e.chk_rpc) begin tests_run++; if (redirect_pc !== e.rpc) begin failed++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end end
      @(posedge clk); #1;
    end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL tgt stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL tgt stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    drive_step(idle("midrst_fetch", 64'h1204, 0, 64'h1208));
    #2 rst_n = 1'b0;
    exp_br = 0; exp_mp = 0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
    tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
    tests_run++; if (mispredict !== e.mp) begin failed++; $display("FAIL %s mispredict got %0b want %0b", e.nm, mispredict, e.mp); end
    tests_run++; if (stat_branches !== exp_br) begin failed++; $display("FAIL midrst stat_branches got %0d want %0d", stat_branches, exp_br); end
    tests_run++; if (stat_mispredicts !== exp_mp) begin failed++; $display("FAIL midrst stat_mispredicts got %0d want %0d", stat_mispredicts, exp_mp); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_step(idle("post_reset_clear", 64'h1100, 0, 64'h1104));
    @(negedge clk);
    e = sb.pop_front();
    tests_run++; if (pred_taken !== e.pt) begin failed++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
    tests_run++; if (pred_target !== e.ptg) begin failed++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptg); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias_conflict();
    test_nonbranch_alias();
    test_target_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
